// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receiver state type and baud-divider helper.
package uart_pkg;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: valid/ready byte stream out of the UART receiver.
interface uart_rx_if;
  import uart_pkg::*;
  logic [DATA_BITS-1:0] m_data_o;
  logic                 m_valid_o;
  logic                 m_ready_i;
  modport master (output m_data_o, output m_valid_o, input m_ready_i);
  modport slave (input m_data_o, input m_valid_o, output m_ready_i);
endinterface

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous input.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  always_ff @(posedge clk) begin
    if (!rst_n) {o_q, r_meta} <= {2{RST_VAL}};
    else {o_q, r_meta} <= {r_meta, i_d};
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit majority vote and valid/ready output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      uart_rx_i,
  uart_rx_if.master m,
  output logic      frame_err_o,
  output logic      overrun_o,
  output logic      busy_o
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int MID = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  generate
    if (CLKS_PER_BIT < 8) begin : g_bad_div
      $error("uart_rx: CLKS_PER_BIT must be at least 8");
    end
  endgenerate
  uart_rx_state_t       r_state, w_state;
  logic                 w_rx, w_wrap, w_done, w_ferr;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_idx;
  logic                 r_s1, r_s2, r_vote, r_vote_v, r_valid;
  logic [DATA_BITS-1:0] r_shift, r_data;
  uart_sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst_n), .i_d(uart_rx_i), .o_q(w_rx));
  assign w_wrap = r_cnt == CW'(CLKS_PER_BIT - 1);
  assign w_done = r_state == STOP && r_vote_v && r_vote;
  assign w_ferr = r_state == STOP && r_vote_v && !r_vote;
  assign busy_o = r_state != IDLE;
  assign m.m_data_o = r_data;
  assign m.m_valid_o = r_valid;
  always_comb begin
    w_state = r_state;
    case (r_state)
      IDLE:    w_state = w_rx ? IDLE : START;
      START:   w_state = (r_vote_v && r_vote) ? IDLE : w_wrap ? DATA : START;
      DATA:    w_state = (w_wrap && r_idx == 3'd7) ? STOP : DATA;
      STOP:    w_state = !r_vote_v ? STOP : r_vote ? IDLE : BREAK;
      BREAK:   w_state = w_rx ? IDLE : BREAK;
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_vote      <= 1'b0;
      r_vote_v    <= 1'b0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= (w_state != r_state || r_state inside {IDLE, BREAK} || w_wrap) ? '0 : r_cnt + 1'b1;
      r_idx    <= r_state != DATA ? '0 : w_wrap ? r_idx + 1'b1 : r_idx;
      if (r_cnt == CW'(MID - 1)) r_s1 <= w_rx;
      if (r_cnt == CW'(MID)) r_s2 <= w_rx;
      if (r_cnt == CW'(MID + 1)) r_vote <= (r_s1 & r_s2) | (r_s1 & w_rx) | (r_s2 & w_rx);
      r_vote_v <= r_cnt == CW'(MID + 1) && r_state inside {START, DATA, STOP};
      if (r_state == DATA && r_vote_v) r_shift[r_idx] <= r_vote;
      frame_err_o <= w_ferr;
      overrun_o   <= w_done && r_valid && !m.m_ready_i;
      // a same-cycle handshake frees the holding register for the new byte
      if (w_done && (!r_valid || m.m_ready_i)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && m.m_ready_i) r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx, scoreboard checks delivered bytes and flag pulses.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int BT = 87;
  localparam int MID = BT / 2;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic ferr, ovr, busy;
  int tests = 0, fails = 0, ferr_cnt = 0, ovr_cnt = 0, hs_cnt = 0;
  logic [7:0] exp_q[$];
  uart_rx_if u_if();
  uart_rx #(.CLK_HZ(10_000_000), .BAUD(115200)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx_i(rx), .m(u_if),
    .frame_err_o(ferr), .overrun_o(ovr), .busy_o(busy)
  );
  always #50 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int bt = BT, input logic stop = 1'b1);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      tick(bt);
    end
    rx = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * BT) begin
      tick(1);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ferr) ferr_cnt++;
      if (ovr) ovr_cnt++;
      if (u_if.m_valid_o && u_if.m_ready_i) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got %0h expected none", u_if.m_data_o);
        end else chk("rx_byte", u_if.m_data_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    int h, f, o, n;
    logic [9:0] fr;
    u_if.m_ready_i = 1'b1;
    tick(3);
    chk("rst_data", u_if.m_data_o, 0);
    chk("rst_valid", u_if.m_valid_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovr", ovr, 0);
    rst_n = 1'b1;
    tick(BT);
    // single byte
    h = hs_cnt;
    exp_q.push_back(8'h3A);
    send(8'h3A);
    tick(5);
    drain("single_drain");
    chk("single_hs", hs_cnt - h, 1);
    chk("single_busy", busy, 0);
    // back-to-back, no idle gap
    h = hs_cnt;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h7E);
    send(8'hA5);
    send(8'h7E);
    drain("b2b_drain");
    chk("b2b_hs", hs_cnt - h, 2);
    chk("b2b_ferr", ferr_cnt, 0);
    chk("b2b_ovr", ovr_cnt, 0);
    // glitch rejection
    h = hs_cnt;
    rx = 1'b0;
    tick(20);
    chk("glitch_busy", busy, 1);
    rx = 1'b1;
    n = 0;
    while (busy && n < MID + 3) begin
      tick(1);
      n++;
    end
    chk("glitch_idle", busy, 0);
    tick(BT);
    chk("glitch_hs", hs_cnt - h, 0);
    exp_q.push_back(8'h55);
    send(8'h55);
    drain("glitch_next");
    // framing error then break
    h = hs_cnt;
    f = ferr_cnt;
    send(8'hFF, BT, 1'b0);
    rx = 1'b0;
    tick(3 * BT);
    rx = 1'b1;
    tick(BT);
    chk("break_ferr", ferr_cnt - f, 1);
    chk("break_hs", hs_cnt - h, 0);
    chk("break_busy", busy, 0);
    exp_q.push_back(8'h01);
    send(8'h01);
    drain("break_next");
    // overrun
    u_if.m_ready_i = 1'b0;
    o = ovr_cnt;
    exp_q.push_back(8'h11);
    send(8'h11);
    send(8'h22);
    tick(5);
    chk("ovr_data", u_if.m_data_o, 8'h11);
    chk("ovr_valid", u_if.m_valid_o, 1);
    chk("ovr_pulse", ovr_cnt - o, 1);
    u_if.m_ready_i = 1'b1;
    tick(1);
    chk("ovr_release", u_if.m_valid_o, 0);
    drain("ovr_drain");
    // reset during data bit 4
    fr = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = fr[i];
      tick(BT);
    end
    rx = fr[5];
    tick(BT / 2);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    tick(1);
    chk("mid_data", u_if.m_data_o, 0);
    chk("mid_valid", u_if.m_valid_o, 0);
    chk("mid_busy0", busy, 0);
    chk("mid_flags", {ferr, ovr}, 0);
    tick(2);
    rst_n = 1'b1;
    rx = 1'b1;
    tick(2 * BT);
    exp_q.push_back(8'hC3);
    send(8'hC3);
    drain("mid_next");
    exp_q.push_back(8'hC3);
    send(8'hC3, 85);
    drain("fast_drain");
    exp_q.push_back(8'hC3);
    send(8'hC3, 89);
    drain("slow_drain");
    tick(BT);
    chk("end_ferr", ferr_cnt, 1);
    chk("end_ovr", ovr_cnt, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8N1, LSB first, idle-high line.
- Samples the asynchronous serial input with a per-bit clock counter and 3-sample majority vote at mid-bit.
- Delivers bytes on a valid/ready stream with framing-error and overrun flags.
- Sits between the board RX pin and the echo/command logic; counterpart to the team's UART transmitter.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- CLKS_PER_BIT, (CLK_HZ + BAUD/2) / BAUD, derived (localparam), clocks per bit, rounded to nearest. Example: 87 at 10 MHz / 115200.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, synchronous active-low reset.
- uart_rx_i, in, 1, asynchronous serial input, idle high.
- m_data_o, out, 8, received byte.
- m_valid_o, out, 1, m_data_o holds an unconsumed byte.
- m_ready_i, in, 1, consumer accepts the byte when m_valid_o && m_ready_i.
- frame_err_o, out, 1, one-cycle pulse on a bad stop bit.
- overrun_o, out, 1, one-cycle pulse when a good byte is dropped.
- busy_o, out, 1, FSM not in IDLE.

Behaviour:
- Interface (decided): one clock `clk`; reset `rst_n` is synchronous and active-low. All state is updated on the rising edge of clk. Reset is sampled only on that edge.
- Reset values:
  - m_data_o = 0, m_valid_o = 0, frame_err_o = 0, overrun_o = 0, busy_o = 0.
  - Synchronizer flops = 1, FSM = IDLE, counters = 0.
- Synchronizer: 2-FF on uart_rx_i; the FSM sees only the synchronized bit rx_s.
- Timing terms:
  - MID = CLKS_PER_BIT/2 (integer division).
  - Vote = majority of rx_s at bit counts MID-1, MID and MID+1; result is registered at count MID+1.
  - The bit counter runs 0..CLKS_PER_BIT-1, then wraps to 0.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rx_s == 0, go to START and clear the counter.
  - START: vote == 1 is a false start; return to IDLE with no flags. vote == 0 goes to DATA at counter wrap, with bit index = 0.
  - DATA: vote shifts into the shift register at bit[index]. After index 7 wraps, go to STOP.
  - STOP: at the vote result, exit without waiting for the bit end, so back-to-back frames can start.
    - vote == 1: frame complete, go to IDLE.
    - vote == 0: pulse frame_err_o; the byte is discarded; go to BREAK.
  - BREAK: wait for rx_s == 1, then go to IDLE. A held-low line yields exactly one frame_err_o pulse.
- Output handshake on frame complete, in the cycle after the stop vote:
  - m_valid_o == 0: load m_data_o and set m_valid_o.
  - m_valid_o == 1 && m_ready_i == 1 in the same cycle: old byte is consumed, new byte is loaded, m_valid_o stays 1.
  - m_valid_o == 1 && m_ready_i == 0: new byte is dropped, m_data_o is unchanged, overrun_o pulses 1 cycle.
- m_valid_o clears on handshake when no new byte is loaded that cycle.
- m_data_o is stable while m_valid_o == 1.
- Latency: about 2 synchronizer cycles + 9.5 bit times + 2 cycles from the start-bit falling edge to m_valid_o.
- Reset mid-frame: everything returns to reset values on the next edge; partial byte is lost; no flags.
- Counter width = $clog2(CLKS_PER_BIT). Elaboration-time assertion: CLKS_PER_BIT >= 8.

Decomposition:
- uart_pkg holds:
  - DATA_BITS = 8.
  - typedef enum uart_rx_state_t {IDLE, START, DATA, STOP, BREAK}.
  - Function clks_per_bit(clk_hz, baud) with the rounding rule above.
  - The transmitter shares this package.
- Sub-module uart_sync2: 2-FF synchronizer with reset value parameter RST_VAL = 1. Reused by other async inputs.

Test Plan (CLK_HZ = 10_000_000, BAUD = 115200, CLKS_PER_BIT = 87):
- Single byte: send 0x3A, m_ready_i = 1 → one m_valid_o cycle with m_data_o = 0x3A; frame_err_o and overrun_o stay 0; busy_o low after the stop vote.
- Back-to-back: send 0xA5 then 0x7E with zero idle gap, ready = 1 → two handshakes in order, 0xA5 then 0x7E, no flags.
- Glitch rejection: drive uart_rx_i low for 20 clks, then high → no m_valid_o, returns to IDLE within MID+3 clks. A following 0x55 is received correctly.
- Framing/break: send 0xFF with stop bit 0, hold the line low 3 bit times, then release → exactly one frame_err_o pulse, no m_valid_o. A following 0x01 is received correctly.
- Overrun: m_ready_i = 0; send 0x11 then 0x22 → m_data_o stays 0x11, one overrun_o pulse at the second completion. Then raise ready → 0x11 accepted and m_valid_o drops next cycle.
- Reset mid-frame and tolerance:
  - Assert rst_n = 0 for 3 clks during data bit 4 → all outputs are 0 next edge; a subsequent 0xC3 is received correctly.
  - Repeat 0xC3 with the stimulus bit time at ±2% → still received correctly.
